// File: rtl/seg_scan_driver_if.sv
// Display data/handshake bundle for seg_scan_driver.
// master = content source (game FSM / bench); slave = the scan driver.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] graphics;
  logic [NUM_DIGITS-1:0]   dots;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    update;
  logic                    update_ack;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   seg_sel;
  logic [7:0]              seg;

  modport master (
    output graphics, dots, blank, blink, update,
    input  update_ack, frame_done, seg_sel, seg
  );

  modport slave (
    input  graphics, dots, blank, blink, update,
    output update_ack, frame_done, seg_sel, seg
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered
// content, per-digit dot/blank/blink and leading dead time in every slot.
// All outputs are registered from the next-state values, so select and
// segment data always switch together.
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_TICKS = 100000,
  parameter int DEAD_TICKS    = 0,
  parameter int BLINK_FRAMES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int TW = $clog2(REFRESH_TICKS);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Active-low glyph table, bit order {center, tl, bl, b, br, tr, t}.
  function automatic logic [6:0] f_decode(input logic [3:0] i_g);
    case (i_g)
      4'h0:    f_decode = 7'b1000000;
      4'h1:    f_decode = 7'b1111001;
      4'h2:    f_decode = 7'b0100100;
      4'h3:    f_decode = 7'b0110000;
      4'h4:    f_decode = 7'b0011001;
      4'h5:    f_decode = 7'b0010010;
      4'h6:    f_decode = 7'b0000010;
      4'h7:    f_decode = 7'b1111000;
      4'h8:    f_decode = 7'b0000000;
      4'h9:    f_decode = 7'b0010000;
      4'hA:    f_decode = 7'b0101011;  // N
      4'hB:    f_decode = 7'b0100001;  // D
      4'hC:    f_decode = 7'b0101111;  // R
      4'hD:    f_decode = 7'b0001000;  // A
      4'hE:    f_decode = 7'b0010101;  // W
      default: f_decode = 7'b1111111;  // off
    endcase
  endfunction

  logic [TW-1:0]           r_tick,    w_tick_nxt;
  logic [DW-1:0]           r_digit,   w_digit_nxt;
  logic [4*NUM_DIGITS-1:0] r_gfx,     w_gfx_nxt;
  logic [NUM_DIGITS-1:0]   r_dots,    w_dots_nxt;
  logic [NUM_DIGITS-1:0]   r_blank,   w_blank_nxt;
  logic [NUM_DIGITS-1:0]   r_blink,   w_blink_nxt;
  logic                    r_pending, w_pending_nxt;
  logic [FW-1:0]           r_fcnt,    w_fcnt_nxt;
  logic                    r_phase,   w_phase_nxt;
  logic [7:0]              r_seg,     w_seg_nxt;
  logic [NUM_DIGITS-1:0]   r_sel,     w_sel_nxt;
  logic                    r_ack,     r_fd;

  logic                    w_slot_end, w_wrap, w_load, w_off;
  logic [4*NUM_DIGITS-1:0] w_gfx_sh;
  logic [NUM_DIGITS-1:0]   w_dots_sh, w_blank_sh, w_blink_sh;
  int                      w_tick_i;

  // Next-state for scan counters, handshake, shadows, blink and outputs.
  always_comb begin
    w_slot_end    = (r_tick == TW'(REFRESH_TICKS - 1));
    w_wrap        = w_slot_end && (r_digit == DW'(NUM_DIGITS - 1));
    w_tick_nxt    = w_slot_end ? '0 : r_tick + TW'(1);
    w_digit_nxt   = r_digit;
    if (w_slot_end) w_digit_nxt = w_wrap ? '0 : r_digit + DW'(1);

    // An update on the boundary cycle itself is taken at that boundary.
    w_load        = w_wrap && (r_pending || bus.update);
    w_pending_nxt = w_load ? 1'b0 : (r_pending || bus.update);
    w_gfx_nxt     = w_load ? bus.graphics : r_gfx;
    w_dots_nxt    = w_load ? bus.dots     : r_dots;
    w_blank_nxt   = w_load ? bus.blank    : r_blank;
    w_blink_nxt   = w_load ? bus.blink    : r_blink;

    w_fcnt_nxt    = r_fcnt;
    w_phase_nxt   = r_phase;
    if (w_wrap) begin
      if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        w_fcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_fcnt_nxt  = r_fcnt + FW'(1);
      end
    end

    // Shift the selected digit down to bit 0 to stay legal at NUM_DIGITS=1.
    w_gfx_sh   = w_gfx_nxt   >> {w_digit_nxt, 2'b00};
    w_dots_sh  = w_dots_nxt  >> w_digit_nxt;
    w_blank_sh = w_blank_nxt >> w_digit_nxt;
    w_blink_sh = w_blink_nxt >> w_digit_nxt;
    w_tick_i   = int'(w_tick_nxt);
    w_off      = (w_tick_i < DEAD_TICKS) || w_blank_sh[0] ||
                 (w_blink_sh[0] && w_phase_nxt);
    w_seg_nxt  = w_off ? 8'hFF : {~w_dots_sh[0], f_decode(w_gfx_sh[3:0])};
    w_sel_nxt  = ~(NUM_DIGITS'(1) << w_digit_nxt);
  end

  // State and output registers; reset restarts the frame and drops pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick    <= '0;
      r_digit   <= '0;
      r_gfx     <= '1;
      r_dots    <= '0;
      r_blank   <= '0;
      r_blink   <= '0;
      r_pending <= 1'b0;
      r_fcnt    <= '0;
      r_phase   <= 1'b0;
      r_seg     <= 8'hFF;
      r_sel     <= ~NUM_DIGITS'(1);
      r_ack     <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_tick    <= w_tick_nxt;
      r_digit   <= w_digit_nxt;
      r_gfx     <= w_gfx_nxt;
      r_dots    <= w_dots_nxt;
      r_blank   <= w_blank_nxt;
      r_blink   <= w_blink_nxt;
      r_pending <= w_pending_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_phase   <= w_phase_nxt;
      r_seg     <= w_seg_nxt;
      r_sel     <= w_sel_nxt;
      r_ack     <= w_load;
      r_fd      <= w_wrap;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.seg_sel    = r_sel;
  assign bus.update_ack = r_ack;
  assign bus.frame_done = r_fd;

endmodule
